// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: blocking miss handler in front of a read-only cache; probes, fills from Avalon-MM on miss, returns the block.
// Optional CACHE_FILL_STATS_EN adds saturating hit_cnt/miss_cnt outputs.
module cache_fill_ctrl #(
  parameter int SIZE_BLOCK = 32,
  parameter int BIT_TOTAL = 24,
  parameter int MEM_ADDR_W = 32,
  parameter logic [MEM_ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [BIT_TOTAL-1:0]  req_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [SIZE_BLOCK-1:0] rsp_data,
  output logic                  c_en,
  output logic                  c_wrt,
  output logic [BIT_TOTAL-1:0]  c_addr,
  output logic [SIZE_BLOCK-1:0] c_wdata,
  input  logic [SIZE_BLOCK-1:0] c_rdata,
  input  logic                  c_success,
  output logic                  m_read,
  output logic [MEM_ADDR_W-1:0] m_address,
  input  logic                  m_waitrequest,
  input  logic [SIZE_BLOCK-1:0] m_readdata,
  input  logic                  m_readdatavalid
`ifdef CACHE_FILL_STATS_EN
  ,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
`endif
);
  typedef enum logic [2:0] {IDLE, LOOKUP, CHECK, MEM_REQ, MEM_WAIT, FILL, RESP} state_e;
  state_e                  state_q;
  logic [BIT_TOTAL-1:0]    addr_q, c_addr_q;
  logic [SIZE_BLOCK-1:0]   data_q, rsp_data_q, c_wdata_q;
  logic                    req_ready_q, rsp_valid_q, c_en_q, c_wrt_q, m_read_q;
  logic [MEM_ADDR_W-1:0]   m_address_q, m_address_d;
  // byte address wraps modulo 2^MEM_ADDR_W
  assign m_address_d = BASE_ADDR + MEM_ADDR_W'(addr_q) * MEM_ADDR_W'(SIZE_BLOCK / 8);
  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign c_en      = c_en_q;
  assign c_wrt     = c_wrt_q;
  assign c_addr    = c_addr_q;
  assign c_wdata   = c_wdata_q;
  assign m_read    = m_read_q;
  assign m_address = m_address_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      c_en_q      <= 1'b0;
      c_wrt_q     <= 1'b0;
      c_addr_q    <= '0;
      c_wdata_q   <= '0;
      m_read_q    <= 1'b0;
      m_address_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            addr_q      <= req_addr;
            c_addr_q    <= req_addr;
            c_en_q      <= 1'b1;
            c_wrt_q     <= 1'b0;
            req_ready_q <= 1'b0;
            state_q     <= LOOKUP;
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        LOOKUP: begin
          c_en_q  <= 1'b0;
          state_q <= CHECK;
        end
        CHECK: begin
          if (c_success) begin
            data_q      <= c_rdata;
            rsp_data_q  <= c_rdata;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            m_read_q    <= 1'b1;
            m_address_q <= m_address_d;
            state_q     <= MEM_REQ;
          end
        end
        MEM_REQ: begin
          if (!m_waitrequest) begin
            m_read_q <= 1'b0;
            state_q  <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (m_readdatavalid) begin
            data_q    <= m_readdata;
            c_en_q    <= 1'b1;
            c_wrt_q   <= 1'b1;
            c_addr_q  <= addr_q;
            c_wdata_q <= m_readdata;
            state_q   <= FILL;
          end
        end
        FILL: begin
          c_en_q      <= 1'b0;
          c_wrt_q     <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= data_q;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef CACHE_FILL_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == CHECK) begin
      if (c_success && hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (!c_success && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb_cache_fill_ctrl: directed scoreboard bench for cache_fill_ctrl with behavioural cache and Avalon memory models.
module tb_cache_fill_ctrl;
  logic clk = 1'b0;
  logic rst, req_valid, req_ready, rsp_valid, rsp_ready;
  logic [23:0] req_addr, c_addr;
  logic [31:0] rsp_data, c_wdata, c_rdata, m_address, m_readdata;
  logic c_en, c_wrt, c_success, m_read, m_waitrequest, m_readdatavalid;
`ifdef CACHE_FILL_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  cache_fill_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .c_en(c_en), .c_wrt(c_wrt), .c_addr(c_addr), .c_wdata(c_wdata), .c_rdata(c_rdata), .c_success(c_success),
    .m_read(m_read), .m_address(m_address), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid)
`ifdef CACHE_FILL_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h0000_000C: return 32'h0000_000A;
      32'h0000_0100: return 32'hDEAD_0064;
      32'h0000_0180: return 32'hCAFE_0096;
      32'h0000_0200: return 32'h0BAD_0080;
      default:       return 32'hDEAD_BEEF;
    endcase
  endfunction

  logic [31:0] rsp_q[$];
  logic [31:0] maddr_q[$];
  logic [55:0] fill_q[$];

  // registered cache: access seen in a cycle answers from the following cycle
  logic [31:0] cm[int];
  initial begin
    logic p_en, p_wrt;
    int p_addr;
    logic [31:0] p_wd;
    p_en = 1'b0; p_wrt = 1'b0; p_addr = 0; p_wd = '0;
    c_success = 1'b0;
    c_rdata = '0;
    forever begin
      tick();
      if (p_en) begin
        if (p_wrt) cm[p_addr] = p_wd;
        else begin
          c_success = cm.exists(p_addr);
          c_rdata = cm.exists(p_addr) ? cm[p_addr] : 32'h0;
        end
      end
      p_en = c_en; p_wrt = c_wrt; p_addr = int'(c_addr); p_wd = c_wdata;
    end
  end

  // Avalon memory: stall holds waitrequest for that many m_read cycles, lat = cycles from accept to readdatavalid
  int lat = 1, stall = 0;
  initial begin
    logic r, busy;
    int cnt, sl;
    logic [31:0] pa;
    r = 1'b0; busy = 1'b0; cnt = 0; sl = 0; pa = '0;
    m_waitrequest = 1'b0;
    m_readdatavalid = 1'b0;
    m_readdata = '0;
    forever begin
      @(posedge clk);
      r = rst;
      #1;
      if (!r) begin
        cnt = 0; sl = 0; busy = 1'b0;
        m_readdatavalid = 1'b0;
        m_waitrequest = 1'b0;
      end else begin
        m_readdatavalid = 1'b0;
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            m_readdatavalid = 1'b1;
            m_readdata = mem_rd(pa);
          end
        end
        if (m_read) begin
          if (!busy) begin
            sl = stall;
            busy = 1'b1;
          end
          m_waitrequest = (sl > 0);
          if (sl > 0) sl--;
          if (!m_waitrequest) begin
            cnt = lat;
            pa = m_address;
            busy = 1'b0;
          end
        end else m_waitrequest = 1'b0;
      end
    end
  end

  // monitor: pops and compares whenever the DUT presents a fill, memory command or response
  int n_rsp = 0, n_reads = 0, mread_cyc = 0, rsp_start = 0;
  logic rv_prev = 1'b0;
  always @(negedge clk) begin
    if (c_en && c_wrt) begin
      chk("fill_expected", 64'(fill_q.size() != 0), 64'd1);
      if (fill_q.size() != 0) begin
        chk("fill_addr", 64'(c_addr), 64'(fill_q[0][55:32]));
        chk("fill_data", 64'(c_wdata), 64'(fill_q[0][31:0]));
        void'(fill_q.pop_front());
      end
    end
    if (m_read) begin
      mread_cyc++;
      chk("mread_expected", 64'(maddr_q.size() != 0), 64'd1);
      if (maddr_q.size() != 0) begin
        chk("m_address", 64'(m_address), 64'(maddr_q[0]));
        if (!m_waitrequest) begin
          void'(maddr_q.pop_front());
          n_reads++;
        end
      end
    end
    if (rsp_valid && !rv_prev) rsp_start = cyc;
    rv_prev = rsp_valid;
    if (rsp_valid && rsp_ready) begin
      chk("rsp_expected", 64'(rsp_q.size() != 0), 64'd1);
      if (rsp_q.size() != 0) chk("rsp_data", 64'(rsp_data), 64'(rsp_q.pop_front()));
      n_rsp++;
    end
  end

  int acc = 0;
  // mode 0: wait for response, 1: response expected later, 2: request will be aborted by reset
  task automatic do_req(input logic [23:0] a, input bit hit, input logic [31:0] d,
                        input int l, input int st, input int mode);
    int tgt;
    lat = l;
    stall = st;
    for (int i = 0; i < 50 && !req_ready; i++) tick();
    chk("req_ready_wait", 64'(req_ready), 64'd1);
    if (mode != 2) begin
      rsp_q.push_back(d);
      if (!hit) fill_q.push_back({a, d});
    end
    if (!hit) maddr_q.push_back(32'(a) * 32'd4);
    tgt = n_rsp + 1;
    req_valid = 1'b1;
    req_addr = a;
    acc = cyc;
    tick();
    req_valid = 1'b0;
    if (mode == 0) begin
      for (int i = 0; i < 300 && n_rsp < tgt; i++) tick();
      chk("rsp_done", 64'(n_rsp), 64'(tgt));
    end
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_data"}, 64'(rsp_data), 64'd0);
    chk({tag, "_c_en"}, 64'(c_en), 64'd0);
    chk({tag, "_c_wrt"}, 64'(c_wrt), 64'd0);
    chk({tag, "_c_addr"}, 64'(c_addr), 64'd0);
    chk({tag, "_c_wdata"}, 64'(c_wdata), 64'd0);
    chk({tag, "_m_read"}, 64'(m_read), 64'd0);
    chk({tag, "_m_address"}, 64'(m_address), 64'd0);
`ifdef CACHE_FILL_STATS_EN
    chk({tag, "_hit_cnt"}, 64'(hit_cnt), 64'd0);
    chk({tag, "_miss_cnt"}, 64'(miss_cnt), 64'd0);
`endif
  endtask

  initial begin
    int b;
    rst = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    cm[32] = 32'h0000_0001;
    tick();
    tick();
    check_reset_outs("init");
    rst = 1'b1;
    tick();
    chk("init_ready", 64'(req_ready), 64'd1);
    // cold miss then hit on the same word
    do_req(24'd3, 1'b0, 32'h0000_000A, 2, 0, 0);
    b = mread_cyc;
    do_req(24'd3, 1'b1, 32'h0000_000A, 1, 0, 0);
    chk("hit_latency", 64'(rsp_start - acc), 64'd3);
    chk("hit_no_mread", 64'(mread_cyc - b), 64'd0);
    // waitrequest stall for 4 cycles
    b = mread_cyc;
    do_req(24'd64, 1'b0, 32'hDEAD_0064, 1, 4, 0);
    chk("stall_mread_cycles", 64'(mread_cyc - b), 64'd5);
    do_req(24'd64, 1'b1, 32'hDEAD_0064, 1, 0, 0);
`ifdef CACHE_FILL_STATS_EN
    chk("stats_hit_cnt", 64'(hit_cnt), 64'd2);
    chk("stats_miss_cnt", 64'(miss_cnt), 64'd2);
`endif
    // response backpressure on a hit
    rsp_ready = 1'b0;
    do_req(24'd32, 1'b1, 32'h0000_0001, 1, 0, 1);
    for (int i = 0; i < 20 && !rsp_valid; i++) tick();
    for (int i = 0; i < 6; i++) begin
      chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_rsp_data", 64'(rsp_data), 64'h1);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_idle_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("bp_idle_req_ready", 64'(req_ready), 64'd1);
    // reset while waiting for memory data
    b = n_reads;
    do_req(24'd128, 1'b0, 32'h0, 1000, 0, 2);
    for (int i = 0; i < 20 && n_reads == b; i++) tick();
    chk("rst_read_issued", 64'(n_reads - b), 64'd1);
    tick();
    rst = 1'b0;
    tick();
    check_reset_outs("midrst");
    rst = 1'b1;
    tick();
    chk("midrst_ready", 64'(req_ready), 64'd1);
    do_req(24'd96, 1'b0, 32'hCAFE_0096, 3, 0, 0);
    tick();
    tick();
    chk("reads_total", 64'(n_reads), 64'd4);
    chk("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
    chk("fill_q_drained", 64'(fill_q.size()), 64'd0);
    chk("maddr_q_drained", 64'(maddr_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish before 2ms");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/cache_fill_ctrl.md
Name: cache_fill_ctrl

Overview:
- Miss-handling stage directly upstream of the read-only cache (cache_ro / cache_ro_multi).
- Accepts word-address read requests from the ray-tracing datapath and probes the cache with a read. On a hit, returns the cached block.
- On a miss, fetches the block from memory over an Avalon-MM read master, writes it into the cache (wrt=1), then returns it.
- Handles one request at a time; blocking.

Parameters:
- SIZE_BLOCK, 32, block/data width in bits; must be a multiple of 8.
- BIT_TOTAL, 24, request/cache address width (word address).
- MEM_ADDR_W, 32, Avalon byte-address width.
- BASE_ADDR, 0, byte base address of the cached region in memory.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset (rst==0 resets on posedge clk)
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_addr  in  BIT_TOTAL  word address requested
- rsp_valid  out  1  response data valid
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  SIZE_BLOCK  returned block
- c_en  out  1  cache enable (to cache en)
- c_wrt  out  1  cache write/fill (to cache wrt)
- c_addr  out  BIT_TOTAL  cache address (to cache i_addr)
- c_wdata  out  SIZE_BLOCK  fill data (to cache i_data)
- c_rdata  in  SIZE_BLOCK  cache o_data
- c_success  in  1  cache o_success (hit)
- m_read  out  1  Avalon read
- m_address  out  MEM_ADDR_W  Avalon byte address
- m_waitrequest  in  1  Avalon waitrequest
- m_readdata  in  SIZE_BLOCK  Avalon read data
- m_readdatavalid  in  1  Avalon read data valid

Behaviour:
- Cache contract:
  - c_rdata and c_success are registered by the cache.
  - They are valid in the cycle after the edge that samples c_en=1.
- Reset: state=IDLE. All of the following are 0: req_ready, rsp_valid, rsp_data, c_en, c_wrt, c_addr, c_wdata, m_read, m_address. The address and data latches are cleared.
- The memory subsystem shares this reset, so no stale readdatavalid can arrive after reset.
- FSM states:
  - IDLE:
    - req_ready=1.
    - On req_valid&&req_ready, latch req_addr into addr_q and go to LOOKUP.
  - LOOKUP (exactly 1 cycle):
    - c_en=1, c_wrt=0, c_addr=addr_q.
    - Go to CHECK.
  - CHECK (1 cycle), sample c_success:
    - 1: data_q<=c_rdata, go to RESP.
    - 0: go to MEM_REQ.
  - MEM_REQ:
    - m_read=1, m_address=BASE_ADDR + addr_q*(SIZE_BLOCK/8). Zero-extend, then truncate modulo 2^MEM_ADDR_W.
    - Hold m_read and m_address stable while m_waitrequest=1.
    - When m_waitrequest=0, the command is accepted; go to MEM_WAIT.
  - MEM_WAIT:
    - m_read=0.
    - On m_readdatavalid: data_q<=m_readdata, go to FILL.
    - No timeout; waits indefinitely.
  - FILL (exactly 1 cycle):
    - c_en=1, c_wrt=1, c_addr=addr_q, c_wdata=data_q.
    - Go to RESP.
  - RESP:
    - rsp_valid=1, rsp_data=data_q.
    - Hold both until rsp_ready; on rsp_valid&&rsp_ready go to IDLE.
- All outputs are decoded from registered state/latches (no input-to-output combinational paths). req_ready is 1 only in IDLE.
- Latency, counted from the accepting edge:
  - Hit: rsp_valid asserts 3 cycles later.
  - Miss with waitrequest=0 and readdatavalid arriving N cycles after MEM_WAIT entry: rsp_valid asserts 5+N cycles later.
- m_readdatavalid outside MEM_WAIT is ignored.
- c_en is never asserted outside LOOKUP and FILL.
- Exactly one memory read is issued per miss; no reads are issued on a hit.
- A new request is not accepted in the same cycle as a response handshake; IDLE is always visited.
- Reset mid-operation (any state): the next cycle is IDLE with all outputs at reset values. An in-flight m_read drops immediately.

Optional Feature:
- Macro CACHE_FILL_STATS_EN.
- When defined:
  - Adds outputs hit_cnt and miss_cnt, each 32 bits.
  - hit_cnt increments on CHECK with c_success=1.
  - miss_cnt increments on CHECK with c_success=0.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- When undefined: the ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Cold miss:
  - Stimulus: req addr 'd3, BASE_ADDR=0; cache returns c_success=0; memory returns 32'hA 2 cycles after accept.
  - Required: m_address=32'hC; fill write c_wrt=1, c_addr=3, c_wdata=32'hA; rsp_data=32'hA.
- Hit:
  - Stimulus: req 'd3; cache returns c_success=1, c_rdata=32'hA.
  - Required: no m_read asserted; rsp_valid exactly 3 cycles after accept; rsp_data=32'hA.
- Waitrequest stall:
  - Stimulus: miss on 'd64 with m_waitrequest=1 for 4 cycles.
  - Required: m_read and m_address=32'h100 held stable for 5 cycles; exactly one read accepted.
- Backpressure:
  - Stimulus: rsp_ready=0 for 6 cycles on a hit of 'd32 with data 32'h1.
  - Required: rsp_valid and rsp_data=32'h1 held; req_ready=0 throughout; IDLE after handshake.
- Reset during MEM_WAIT:
  - Stimulus: rst=0 for 1 cycle.
  - Required: next cycle all outputs 0 and req_ready=0 during reset; req_ready=1 the cycle after release; a following request to 'd96 completes normally.
- Stats (CACHE_FILL_STATS_EN):
  - Stimulus: sequence miss 3, hit 3, miss 64, hit 64.
  - Required: hit_cnt=2, miss_cnt=2.
